fetch_buffer: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter. It turns each PC value into an instruction-memory request, tracks up to DEPTH requests in an in-order slot buffer, and hands completed instruction/PC pairs to the decode stage (IF/ID) over a valid/ready handshake. It throttles the PC through `stall_out` whenever it cannot accept a new fetch address.

---
 rtl/fetch_buffer.sv | 167 ++++++++++++++++
 tb/tb_fetch_buffer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch stage between the PC and decode.
// Turns each PC value into an instruction-memory request, tracks up to DEPTH
// outstanding/completed fetches in an in-order slot ring, and presents the
// oldest completed instruction/PC pair to decode over a valid/ready handshake.
//
// Optional feature macro: FETCH_FLUSH_EN
//   defined   - flush discards all buffered and in-flight work; responses still
//               owed to flushed requests are counted and dropped on arrival.
//   undefined - flush is ignored; redirects must drain the buffer externally.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   pc_in               fetch address from the PC
//   stall_out           high = hold the PC (no request accepted this cycle)
//   imem_req_*          request to instruction memory (addr = pc_in)
//   imem_rsp_*          in-order response beats from instruction memory
//   flush               branch/jump redirect
//   id_valid/instr/pc   head instruction to decode
//   id_ready            decode consumes the head this cycle
module fetch_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              stall_out,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              flush,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [DATA_W-1:0] r_instr [DEPTH];
    logic [DEPTH-1:0]  r_filled;
    logic [PW-1:0]     r_alloc;
    logic [PW-1:0]     r_fill;
    logic [PW-1:0]     r_head;
    logic [CW-1:0]     r_used;
    // Allocated slots still waiting for their response.
    logic [CW-1:0]     r_inflight;
    // Last head shown to decode, held on the outputs while the buffer is empty.
    logic [DATA_W-1:0] r_last_instr;
    logic [ADDR_W-1:0] r_last_pc;

    logic              w_flush;
    logic [CW-1:0]     w_discard;
    logic              w_pop;
    logic              w_fire;
    logic              w_rsp_fill;
    logic [CW:0]       w_occ;
    logic [DEPTH-1:0]  w_filled_d;

`ifdef FETCH_FLUSH_EN
    logic [CW-1:0]     r_discard;

    assign w_flush   = flush;
    assign w_discard = r_discard;

    // Each response arriving in the flush cycle consumes one owed beat,
    // whether it was owed to discard or to a slot being flushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_discard <= '0;
        end else if (w_flush) begin
            r_discard <= r_discard + r_inflight
                       - CW'(imem_rsp_valid && ((r_discard != '0) || (r_inflight != '0)));
        end else begin
            r_discard <= r_discard - CW'(imem_rsp_valid && (r_discard != '0));
        end
    end
`else
    logic w_unused_flush;

    assign w_unused_flush = flush;
    assign w_flush        = 1'b0;
    assign w_discard      = '0;
`endif

    assign id_valid = r_filled[r_head];
    assign id_instr = id_valid ? r_instr[r_head] : r_last_instr;
    assign id_pc    = id_valid ? r_pc[r_head]    : r_last_pc;

    assign w_pop = id_valid && id_ready && !w_flush;

    // Credit check counts a pop in the same cycle, so a full buffer can accept
    // a new request in the very cycle decode frees the head slot.
    assign w_occ          = ({1'b0, r_used} + {1'b0, w_discard}) - (CW+1)'(w_pop);
    assign imem_req_valid = reset_n && !w_flush && (w_occ < DEPTH_W);
    assign imem_req_addr  = pc_in;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign stall_out      = !w_fire;

    // Responses with nothing owed and no unfilled slot are ignored.
    assign w_rsp_fill = imem_rsp_valid && (w_discard == '0) && (r_inflight != '0);

    always_comb begin
        w_filled_d = r_filled;
        if (w_fire) begin
            w_filled_d[r_alloc] = 1'b0;
        end
        if (w_rsp_fill) begin
            w_filled_d[r_fill] = 1'b1;
        end
        if (w_pop) begin
            w_filled_d[r_head] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
            r_filled     <= '0;
            r_alloc      <= '0;
            r_fill       <= '0;
            r_head       <= '0;
            r_used       <= '0;
            r_inflight   <= '0;
            r_last_instr <= '0;
            r_last_pc    <= '0;
        end else begin
            if (id_valid) begin
                r_last_instr <= r_instr[r_head];
                r_last_pc    <= r_pc[r_head];
            end
            if (w_flush) begin
                r_filled   <= '0;
                r_alloc    <= '0;
                r_fill     <= '0;
                r_head     <= '0;
                r_used     <= '0;
                r_inflight <= '0;
            end else begin
                if (w_fire) begin
                    r_pc[r_alloc] <= pc_in;
                    r_alloc       <= r_alloc + PW'(1);
                end
                if (w_rsp_fill) begin
                    r_instr[r_fill] <= imem_rsp_data;
                    r_fill          <= r_fill + PW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                r_filled   <= w_filled_d;
                r_used     <= r_used + CW'(w_fire) - CW'(w_pop);
                r_inflight <= r_inflight + CW'(w_fire) - CW'(w_rsp_fill);
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer (DEPTH=4).
// The bench plays the PC (advances by 4 on each accepted request) and a
// 1-cycle-latency instruction memory whose word at address A is 0x20080005+A.
// Responses can be held back with mem_on=0 to keep requests in flight.
module tb_fetch_buffer;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_in;
    logic        stall_out;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    logic [31:0] q[$];
    bit          mem_on;
    bit          fired;
    logic [31:0] pc;
    int          n_checks;
    int          n_errors;

    fetch_buffer #(
        .DEPTH  (4),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_in          (pc_in),
        .stall_out      (stall_out),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_0005 + a;
    endfunction

    // First half of a cycle: drive the memory response, then settle to negedge.
    task automatic half();
        if (mem_on && q.size() != 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        pc_in = pc;
        @(negedge clk);
        fired = imem_req_valid && imem_req_ready;
    endtask

    // Second half: clock edge, record an accepted request, advance the PC.
    task automatic fin();
        @(posedge clk);
        if (fired) begin
            q.push_back(pc);
            pc = pc + 32'd4;
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        flush          = 1'b0;
        id_ready       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        q.delete();
        mem_on = 1'b1;
        pc     = '0;
        pc_in  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        flush          = 1'b0;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hdead_beef;
        pc_in          = 32'h40;
        @(posedge clk);
        #1;
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid);
        end
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
        end
        n_checks++;
        if (stall_out !== 1'b1) begin
            n_errors++; $display("FAIL reset_stall: got %b want 1", stall_out);
        end
        n_checks++;
        if (id_instr !== 32'h0) begin
            n_errors++; $display("FAIL reset_id_instr: got %h want 0", id_instr);
        end
        n_checks++;
        if (id_pc !== 32'h0) begin
            n_errors++; $display("FAIL reset_id_pc: got %h want 0", id_pc);
        end
    endtask

    task automatic test_first_fetch();
        do_reset();
        imem_req_ready = 1'b1;
        // Cycle 1: request for PC 0 goes out, PC released.
        half();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL first_req: got valid=%b addr=%h want 1/0", imem_req_valid, imem_req_addr);
        end
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_errors++; $display("FAIL first_stall: got %b want 0", stall_out);
        end
        fin();
        // Cycle 2: response arrives, not yet visible.
        half();
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++; $display("FAIL first_c2_valid: got %b want 0", id_valid);
        end
        n_checks++;
        if (imem_req_addr !== 32'h4) begin
            n_errors++; $display("FAIL first_c2_addr: got %h want 4", imem_req_addr);
        end
        fin();
        // Cycle 3: delivered.
        half();
        n_checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'h2008_0005 || id_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL first_deliver: got v=%b instr=%h pc=%h want 1/20080005/0",
                     id_valid, id_instr, id_pc);
        end
        fin();
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        exp_pc         = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            half();
            if (c >= 3) begin
                n_checks++;
                if (id_valid !== 1'b1) begin
                    n_errors++; $display("FAIL stream_bubble c%0d: got %b want 1", c, id_valid);
                end
                n_checks++;
                if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc)) begin
                    n_errors++;
                    $display("FAIL stream_data c%0d: got pc=%h instr=%h want %h/%h",
                             c, id_pc, id_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            fin();
        end
    endtask

    task automatic test_full();
        int nfire;
        do_reset();
        imem_req_ready = 1'b1;
        nfire          = 0;
        for (int c = 1; c <= 8; c++) begin
            half();
            if (fired) nfire++;
            fin();
        end
        n_checks++;
        if (nfire != 4) begin
            n_errors++; $display("FAIL full_fires: got %0d want 4", nfire);
        end
        half();
        n_checks++;
        if (stall_out !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL full_stall: got stall=%b req=%b want 1/0", stall_out, imem_req_valid);
        end
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            n_errors++; $display("FAIL full_head: got v=%b pc=%h want 1/0", id_valid, id_pc);
        end
        fin();
        // One pop frees a slot and the held PC 0x10 is requested in that cycle.
        id_ready = 1'b1;
        half();
        if (fired) nfire++;
        n_checks++;
        if (imem_req_valid !== 1'b1 || stall_out !== 1'b0 || imem_req_addr !== 32'h10) begin
            n_errors++;
            $display("FAIL full_release: got req=%b stall=%b addr=%h want 1/0/10",
                     imem_req_valid, stall_out, imem_req_addr);
        end
        fin();
        id_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            half();
            if (fired) nfire++;
            fin();
        end
        n_checks++;
        if (nfire != 5) begin
            n_errors++; $display("FAIL full_refill_count: got %0d want 5", nfire);
        end
        half();
        n_checks++;
        if (stall_out !== 1'b1 || id_pc !== 32'h4 || id_instr !== 32'h2008_0009) begin
            n_errors++;
            $display("FAIL full_after_pop: got stall=%b pc=%h instr=%h want 1/4/20080009",
                     stall_out, id_pc, id_instr);
        end
        fin();
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_req_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            half();
            fin();
        end
        imem_req_ready = 1'b0;
        half();
        fin();
        half();
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            n_errors++; $display("FAIL areset_pre: got v=%b pc=%h want 1/0", id_valid, id_pc);
        end
        fin();
        imem_req_ready = 1'b1;
        #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_errors++; $display("FAIL areset_pre_stall: got %b want 0", stall_out);
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (id_valid !== 1'b0 || stall_out !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_now: got v=%b stall=%b req=%b want 0/1/0",
                     id_valid, stall_out, imem_req_valid);
        end
        n_checks++;
        if (id_pc !== 32'h0 || id_instr !== 32'h0) begin
            n_errors++; $display("FAIL areset_data: got pc=%h instr=%h want 0/0", id_pc, id_instr);
        end
    endtask

`ifdef FETCH_FLUSH_EN
    task automatic test_flush_inflight();
        do_reset();
        imem_req_ready = 1'b1;
        half(); fin();
        half(); fin();
        mem_on = 1'b0;
        half(); fin();
        // Slot 0 filled, PCs 4 and 8 still in flight; redirect to 0x100.
        flush = 1'b1;
        pc    = 32'h100;
        half();
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL fl_req_suppress: got %b want 0", imem_req_valid);
        end
        fin();
        flush  = 1'b0;
        mem_on = 1'b1;
        half();
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++; $display("FAIL fl_valid_c5: got %b want 0", id_valid);
        end
        n_checks++;
        if (dut.r_discard !== 3'd2) begin
            n_errors++; $display("FAIL fl_discard: got %0d want 2", dut.r_discard);
        end
        fin();
        for (int c = 6; c <= 7; c++) begin
            half();
            n_checks++;
            if (id_valid !== 1'b0) begin
                n_errors++; $display("FAIL fl_valid_c%0d: got %b want 0", c, id_valid);
            end
            fin();
        end
        half();
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h2008_0105) begin
            n_errors++;
            $display("FAIL fl_first_post: got v=%b pc=%h instr=%h want 1/100/20080105",
                     id_valid, id_pc, id_instr);
        end
        fin();
    endtask

    task automatic test_flush_pop();
        do_reset();
        imem_req_ready = 1'b1;
        half(); fin();
        half(); fin();
        half(); fin();
        mem_on = 1'b0;
        half(); fin();
        // Slots: 0,4 filled; 8,C in flight. Flush meets response for 8 and a pop.
        mem_on   = 1'b1;
        flush    = 1'b1;
        id_ready = 1'b1;
        pc       = 32'h200;
        half();
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL fp_req_suppress: got %b want 0", imem_req_valid);
        end
        fin();
        flush = 1'b0;
        half();
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++; $display("FAIL fp_no_delivery: got %b want 0", id_valid);
        end
        n_checks++;
        if (dut.r_discard !== 3'd1) begin
            n_errors++; $display("FAIL fp_discard: got %0d want 1", dut.r_discard);
        end
        n_checks++;
        if (dut.r_head !== 2'd0 || dut.r_alloc !== 2'd0 || dut.r_fill !== 2'd0) begin
            n_errors++;
            $display("FAIL fp_pointers: got head=%0d alloc=%0d fill=%0d want 0/0/0",
                     dut.r_head, dut.r_alloc, dut.r_fill);
        end
        fin();
        half();
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++; $display("FAIL fp_valid_c7: got %b want 0", id_valid);
        end
        fin();
        half();
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== 32'h2008_0205) begin
            n_errors++;
            $display("FAIL fp_first_post: got v=%b pc=%h instr=%h want 1/200/20080205",
                     id_valid, id_pc, id_instr);
        end
        fin();
    endtask
`else
    task automatic test_flush_ignored();
        do_reset();
        imem_req_ready = 1'b1;
        flush          = 1'b1;
        half();
        n_checks++;
        if (imem_req_valid !== 1'b1) begin
            n_errors++; $display("FAIL noflush_req: got %b want 1", imem_req_valid);
        end
        fin();
        half(); fin();
        half();
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            n_errors++; $display("FAIL noflush_deliver: got v=%b pc=%h want 1/0", id_valid, id_pc);
        end
        fin();
        flush = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        mem_on   = 1'b1;
        fired    = 1'b0;
        pc       = '0;
        test_reset();
        test_first_fetch();
        test_stream();
        test_full();
`ifdef FETCH_FLUSH_EN
        test_flush_inflight();
        test_flush_pop();
`else
        test_flush_ignored();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
